muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide unit. It accepts one M-extension op from the execute stage over a valid/ready handshake and computes on operand magnitudes. Multiply runs on a fixed-latency multicycle product; divide runs on a 1-bit-per-cycle restoring divider. A sign-fixup step then applies RISC-V signed/unsigned semantics, and the block returns the 32-bit result with the destination tag.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_ctrl_if.sv | 33 +++
 rtl/muldiv_div_iter.sv | 67 ++++++
 rtl/muldiv_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ==========================================================================
// muldiv_pkg : RV32M op encodings, sequencer states and op decode helpers
// Rev 1.0
// ==========================================================================
package muldiv_pkg;

   localparam int MUL_LAT_DEFAULT = 2;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic a_signed(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic b_signed(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ==========================================================================
// muldiv_ctrl_if : request/response bundle between execute and mul/div unit
// Rev 1.0
// ==========================================================================
interface muldiv_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [XLEN-1:0]  req_a;
   logic [XLEN-1:0]  req_b;
   logic [TAG_W-1:0] req_tag;
   logic             flush;
   logic             resp_valid;
   logic             resp_ready;
   logic [XLEN-1:0]  resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             busy;

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag, flush, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_tag, busy
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag, flush, resp_ready,
      output req_ready, resp_valid, resp_data, resp_tag, busy
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_div_iter.sv
`default_nettype none
// ==========================================================================
// muldiv_div_iter : unsigned restoring divider, one quotient bit per cycle
// Rev 1.0
// ==========================================================================
module muldiv_div_iter #(
   parameter int XLEN = 32
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire logic            start,
   input  wire logic            kill,
   input  wire logic [XLEN-1:0] dividend,
   input  wire logic [XLEN-1:0] divisor,
   output logic                 done,
   output logic [XLEN-1:0]      quotient,
   output logic [XLEN-1:0]      remainder
);
   localparam int              CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

   logic [XLEN-1:0]  r_q;
   logic [XLEN-1:0]  r_r;
   logic [XLEN-1:0]  r_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_run;
   logic [XLEN:0]    w_shift;
   logic [XLEN:0]    w_trial;

   // One extra bit holds the partial remainder after the shift; a clear top bit means it fits.
   assign w_shift = {r_r, r_q[XLEN-1]};
   assign w_trial = w_shift - {1'b0, r_d};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q   <= '0;
         r_r   <= '0;
         r_d   <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (kill) begin
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (start) begin
         r_q   <= dividend;
         r_r   <= '0;
         r_d   <= divisor;
         r_cnt <= '0;
         r_run <= 1'b1;
      end else if (r_run) begin
         if (!w_trial[XLEN]) begin
            r_r <= w_trial[XLEN-1:0];
            r_q <= {r_q[XLEN-2:0], 1'b1};
         end else begin
            r_r <= w_shift[XLEN-1:0];
            r_q <= {r_q[XLEN-2:0], 1'b0};
         end
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST) r_run <= 1'b0;
      end
   end

   assign done      = r_run && (r_cnt == LAST);
   assign quotient  = r_q;
   assign remainder = r_r;
endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ==========================================================================
// muldiv_ctrl : RV32M mul/div sequencer (optional MULDIV_REUSE_EN result reuse)
// Rev 1.0
// ==========================================================================
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = MUL_LAT_DEFAULT,
   parameter int TAG_W   = 5
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   muldiv_ctrl_if.slave bus
);
   localparam logic [2:0]      CNT_LAST = 3'(MUL_LAT - 1);
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_op;
   logic                r_a_neg;
   logic                r_b_neg;
   logic [XLEN-1:0]     r_mag_a;
   logic [XLEN-1:0]     r_mag_b;
   logic [XLEN-1:0]     r_data;
   logic [TAG_W-1:0]    r_tag;
   logic [2:0]          r_cnt;
   logic [2*XLEN-1:0]   r_prod;
   logic [2*XLEN-1:0]   w_prod;
   logic [2*XLEN-1:0]   w_prod_fix;

   logic                w_accept;
   logic                w_div_op;
   logic                w_a_neg;
   logic                w_b_neg;
   logic                w_div0;
   logic                w_ovf;
   logic                w_special;
   logic                w_hit;
   logic                w_div_start;
   logic                w_div_done;
   logic                w_mul_last;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic [XLEN-1:0]     w_special_res;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_q_fix;
   logic [XLEN-1:0]     w_r_fix;
   logic [XLEN-1:0]     w_fix_res;

   // Request decode
   assign w_div_op    = is_div(bus.req_op);
   assign w_a_neg     = a_signed(bus.req_op) && bus.req_a[XLEN-1];
   assign w_b_neg     = b_signed(bus.req_op) && bus.req_b[XLEN-1];
   assign w_mag_a     = w_a_neg ? -bus.req_a : bus.req_a;
   assign w_mag_b     = w_b_neg ? -bus.req_b : bus.req_b;
   assign w_div0      = (bus.req_b == '0);
   assign w_ovf       = a_signed(bus.req_op) && (bus.req_a == INT_MIN) && (bus.req_b == '1);
   assign w_special   = w_div_op && (w_div0 || w_ovf);
   assign w_accept    = (r_state == ST_IDLE) && !bus.flush && bus.req_valid;
   assign w_div_start = w_accept && w_div_op && !w_special && !w_hit;
   assign w_mul_last  = (r_state == ST_MUL) && (r_cnt == CNT_LAST);

   // op[1] separates REM/REMU from DIV/DIVU
   always_comb begin
      w_special_res = '1;
      if (w_div0) w_special_res = bus.req_op[1] ? bus.req_a : '1;
      else        w_special_res = bus.req_op[1] ? '0 : INT_MIN;
   end

   // Held operands make this a multicycle path, sampled on the last MUL count
   assign w_prod = {{XLEN{1'b0}}, r_mag_a} * {{XLEN{1'b0}}, r_mag_b};

   assign w_prod_fix = (r_a_neg ^ r_b_neg) ? -r_prod : r_prod;
   assign w_q_fix    = (r_a_neg ^ r_b_neg) ? -w_quo : w_quo;
   assign w_r_fix    = r_a_neg ? -w_rem : w_rem;

   always_comb begin
      w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      if (is_div(r_op))         w_fix_res = r_op[1] ? w_r_fix : w_q_fix;
      else if (r_op == MD_MUL)  w_fix_res = w_prod_fix[XLEN-1:0];
   end

   muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (w_div_start),
      .kill      (bus.flush),
      .dividend  (w_mag_a),
      .divisor   (w_mag_b),
      .done      (w_div_done),
      .quotient  (w_quo),
      .remainder (w_rem)
   );

`ifdef MULDIV_REUSE_EN
   logic            r_hit_valid;
   logic [XLEN-1:0] r_last_a;
   logic [XLEN-1:0] r_last_b;
   logic            r_last_cls;
   logic            r_last_sa;
   logic            r_last_sb;

   // The product register and divider outputs already hold the last result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hit_valid <= 1'b0;
         r_last_a    <= '0;
         r_last_b    <= '0;
         r_last_cls  <= 1'b0;
         r_last_sa   <= 1'b0;
         r_last_sb   <= 1'b0;
      end else if (bus.flush) begin
         r_hit_valid <= 1'b0;
      end else begin
         if (w_accept && !w_special && !w_hit) begin
            r_hit_valid <= 1'b0;
            r_last_a    <= bus.req_a;
            r_last_b    <= bus.req_b;
            r_last_cls  <= w_div_op;
            r_last_sa   <= a_signed(bus.req_op);
            r_last_sb   <= b_signed(bus.req_op);
         end
         if (w_mul_last || ((r_state == ST_DIV) && w_div_done)) r_hit_valid <= 1'b1;
      end
   end

   assign w_hit = r_hit_valid && (r_last_a == bus.req_a) && (r_last_b == bus.req_b) &&
                  (r_last_cls == w_div_op) && (r_last_sa == a_signed(bus.req_op)) &&
                  (r_last_sb == b_signed(bus.req_op));
`else
   assign w_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.busy       = 1'b1;
      case (r_state)
         ST_IDLE: begin
            bus.busy      = 1'b0;
            bus.req_ready = !bus.flush;
            if (w_accept) begin
               if (w_special)     w_next = ST_DONE;
               else if (w_hit)    w_next = ST_FIX;
               else if (w_div_op) w_next = ST_DIV;
               else               w_next = ST_MUL;
            end
         end
         ST_MUL:  if (w_mul_last) w_next = ST_FIX;
         ST_DIV:  if (w_div_done) w_next = ST_FIX;
         ST_FIX:  w_next = ST_DONE;
         ST_DONE: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      if (bus.flush && (r_state != ST_IDLE)) w_next = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op    <= '0;
         r_a_neg <= 1'b0;
         r_b_neg <= 1'b0;
         r_mag_a <= '0;
         r_mag_b <= '0;
         r_data  <= '0;
         r_tag   <= '0;
         r_cnt   <= '0;
         r_prod  <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= bus.req_op;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_tag   <= bus.req_tag;
            r_cnt   <= '0;
            if (w_special) r_data <= w_special_res;
         end
         if (r_state == ST_MUL) r_cnt  <= r_cnt + 1'b1;
         if (w_mul_last)        r_prod <= w_prod;
         if (r_state == ST_FIX) r_data <= w_fix_res;
      end
   end

   assign bus.resp_data = r_data;
   assign bus.resp_tag  = r_tag;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_muldiv_ctrl : directed vector table, corner sequences and random ops
// Rev 1.0
// ==========================================================================
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int MUL_LAT = 2;
   localparam int NVEC    = 22;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   muldiv_ctrl_if #(.XLEN(32), .TAG_W(5)) bus ();

   muldiv_ctrl #(.XLEN(32), .MUL_LAT(MUL_LAT), .TAG_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [NVEC];

`ifdef MULDIV_REUSE_EN
   logic        m_valid = 1'b0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic        m_cls = 1'b0;
   logic        m_sa = 1'b0;
   logic        m_sb = 1'b0;
`endif

   function automatic logic op_sa(input logic [2:0] op);
      return (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
   endfunction

   function automatic logic op_sb(input logic [2:0] op);
      return (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
   endfunction

   function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      return op[2] && ((b == 32'd0) || (op_sa(op) && (a == 32'h80000000) && (b == 32'hFFFFFFFF)));
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (is_special(op, a, b)) return 1;
`ifdef MULDIV_REUSE_EN
      if (m_valid && (m_a == a) && (m_b == b) && (m_cls == op[2]) &&
          (m_sa == op_sa(op)) && (m_sb == op_sb(op))) return 2;
`endif
      return op[2] ? 34 : MUL_LAT + 2;
   endfunction

   task automatic model_note(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_REUSE_EN
      if (!is_special(op, a, b)) begin
         m_valid = 1'b1; m_a = a; m_b = b; m_cls = op[2]; m_sa = op_sa(op); m_sb = op_sb(op);
      end
`else
      if (op === 3'bxxx) $display("note: op %0d a %h b %h", op, a, b);
`endif
   endtask

   task automatic model_clear();
`ifdef MULDIV_REUSE_EN
      m_valid = 1'b0;
`endif
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xs, xu, ys, yu, p;
      logic [31:0] r;
      int ai, bi;
      xs = {{32{a[31]}}, a}; xu = {32'd0, a};
      ys = {{32{b[31]}}, b}; yu = {32'd0, b};
      ai = a; bi = b;
      p = '0; r = '0;
      case (op)
         3'd0: begin p = xu * yu; r = p[31:0];  end
         3'd1: begin p = xs * ys; r = p[63:32]; end
         3'd2: begin p = xs * yu; r = p[63:32]; end
         3'd3: begin p = xu * yu; r = p[63:32]; end
         3'd4: if (b == 0) r = '1; else if (a == 32'h80000000 && b == '1) r = a; else r = ai / bi;
         3'd6: if (b == 0) r = a;  else if (a == 32'h80000000 && b == '1) r = 0; else r = ai % bi;
         3'd5: if (b == 0) r = '1; else r = a / b;
         default: if (b == 0) r = a; else r = a % b;
      endcase
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
      int lat;
      int exp_lat;
      exp_lat = ref_lat(op, a, b);
      @(negedge clk);
      check({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({nm, " latency"}, 32'(lat), 32'(exp_lat));
      check({nm, " data"}, bus.resp_data, exp);
      check({nm, " tag"}, 32'(bus.resp_tag), 32'(tag));
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      check({nm, " idle after handshake"}, {31'd0, bus.busy}, 32'd0);
      model_note(op, a, b);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      logic seen;
      logic [2:0] rop;
      logic [31:0] ra, rb;

      vecs[0]  = '{MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
      vecs[1]  = '{MD_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF};
      vecs[2]  = '{MD_MULHU,  32'd7,        32'hFFFFFFFD, 32'h00000006};
      vecs[3]  = '{MD_MULHSU, 32'd7,        32'hFFFFFFFD, 32'h00000006};
      vecs[4]  = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
      vecs[5]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[6]  = '{MD_MUL,    32'h80000000, 32'h80000000, 32'h00000000};
      vecs[7]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[8]  = '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
      vecs[9]  = '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
      vecs[10] = '{MD_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC};
      vecs[11] = '{MD_REMU,   32'hFFFFFFF9, 32'd2,        32'h00000001};
      vecs[12] = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
      vecs[13] = '{MD_REMU,   32'd5,        32'd0,        32'h00000005};
      vecs[14] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      vecs[15] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
      vecs[16] = '{MD_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2};
      vecs[17] = '{MD_REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE};
      vecs[18] = '{MD_DIV,    32'h80000000, 32'd1,        32'h80000000};
      vecs[19] = '{MD_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
      vecs[20] = '{MD_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
      vecs[21] = '{MD_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};

      bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
      bus.req_tag = '0; bus.flush = 1'b0; bus.resp_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset req_ready",  {31'd0, bus.req_ready},  32'd1);
      check("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("reset resp_data",  bus.resp_data,           32'd0);
      check("reset resp_tag",   32'(bus.resp_tag),       32'd0);
      check("reset busy",       {31'd0, bus.busy},       32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3), vecs[i].exp);

      // Backpressure: result must hold while resp_ready is low and no second op enters
      @(negedge clk);
      lat = ref_lat(MD_MUL, 32'd3, 32'd5);
      bus.req_valid = 1'b1; bus.req_op = MD_MUL; bus.req_a = 32'd3; bus.req_b = 32'd5; bus.req_tag = 5'd9;
      @(posedge clk); #1;
      bus.req_op = MD_DIVU; bus.req_a = 32'd100; bus.req_b = 32'd3; bus.req_tag = 5'd21;
      begin
         int n;
         n = 1;
         while (!bus.resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         check("bp latency", 32'(n), 32'(lat));
      end
      model_note(MD_MUL, 32'd3, 32'd5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp resp_valid", {31'd0, bus.resp_valid}, 32'd1);
         check("bp data",       bus.resp_data,           32'd15);
         check("bp tag",        32'(bus.resp_tag),       32'd9);
         check("bp req_ready",  {31'd0, bus.req_ready},  32'd0);
      end
      @(negedge clk);
      bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      check("bp released valid", {31'd0, bus.resp_valid}, 32'd0);
      check("bp released busy",  {31'd0, bus.busy},       32'd0);
      @(posedge clk); #1;
      check("bp no second accept", {31'd0, bus.busy}, 32'd0);

      // Flush during a divide at cycle 15
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = MD_DIV; bus.req_a = 32'd1000; bus.req_b = 32'd3; bus.req_tag = 5'd4;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      model_clear();
      check("flush busy",       {31'd0, bus.busy},       32'd0);
      check("flush resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) seen = 1'b1;
      end
      check("flush no response", {31'd0, seen}, 32'd0);

      // A request presented in a flush cycle while idle is ignored
      @(negedge clk);
      bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_op = MD_MULHU; bus.req_a = 32'd2; bus.req_b = 32'd2;
      #1;
      check("flush idle req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.req_valid = 1'b0;
      check("flush idle no accept", {31'd0, bus.busy}, 32'd0);
      run_op("post-flush mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFF);

      // Reset mid-MUL
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = MD_MUL; bus.req_a = 32'd9; bus.req_b = 32'd9; bus.req_tag = 5'd7;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      check("midrst req_ready",  {31'd0, bus.req_ready},  32'd1);
      check("midrst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("midrst resp_data",  bus.resp_data,           32'd0);
      check("midrst resp_tag",   32'(bus.resp_tag),       32'd0);
      check("midrst busy",       {31'd0, bus.busy},       32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) seen = 1'b1;
      end
      check("midrst no response", {31'd0, seen}, 32'd0);

      // Random ops against the reference model
      for (int i = 0; i < 1500; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick();
         rb  = pick();
         run_op($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb,
                5'($urandom_range(0, 31)), ref_res(rop, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
